// File: rtl/mem_stage_if.sv
// Bundle between the EX/MEM boundary and the MEM/WB register of mem_stage.
// The master drives instructions into the stage; the slave is the stage itself.
interface mem_stage_if;
  logic        hold;
  logic        valid_in;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg_in;
  logic        reg_write_in;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        valid_out;
  logic        mem_to_reg;
  logic        reg_write;
  logic [31:0] data_in;
  logic [31:0] dir;
  logic [4:0]  rd_out;
  logic        misalign;

  modport master (
    output hold, valid_in, mem_read, mem_write, mem_to_reg_in, reg_write_in,
           size, unsigned_ld, alu_result, store_data, rd_in,
    input  valid_out, mem_to_reg, reg_write, data_in, dir, rd_out, misalign
  );

  modport slave (
    input  hold, valid_in, mem_read, mem_write, mem_to_reg_in, reg_write_in,
           size, unsigned_ld, alu_result, store_data, rd_in,
    output valid_out, mem_to_reg, reg_write, data_in, dir, rd_out, misalign
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: byte/half/word loads and stores on a lane-split
// data RAM, plus the MEM/WB register feeding wb_stage.
module mem_stage #(
  parameter int ADDR_W = 8
) (
  input logic       clk,
  input logic       reset,
  mem_stage_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_off;
  logic              misalign_now;
  logic [3:0]        lane_en;
  logic [31:0]       wr_data;
  logic              store_en;
  logic              load_en;
  logic [31:0]       raw_word;

  assign word_idx = bus.alu_result[ADDR_W+1:2];
  assign byte_off = bus.alu_result[1:0];

  always_comb begin
    misalign_now = 1'b0;
    lane_en      = 4'b1111;
    wr_data      = bus.store_data;
    case (bus.size)
      2'b00: begin
        lane_en = 4'b0001 << byte_off;
        wr_data = {4{bus.store_data[7:0]}};
      end
      2'b01: begin
        misalign_now = byte_off[0];
        lane_en      = byte_off[1] ? 4'b1100 : 4'b0011;
        wr_data      = {2{bus.store_data[15:0]}};
      end
      default: misalign_now = (byte_off != 2'b00);
    endcase
  end

  // Reset blocks writes so an instruction in flight at reset assertion is dropped.
  assign store_en = ~reset & ~bus.hold & bus.valid_in & bus.mem_write & ~misalign_now;
  assign load_en  = ~bus.hold & bus.valid_in & bus.mem_read;

  // One RAM per byte lane; read-first so a combined load/store sees the old word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_q;
      always_ff @(posedge clk) begin
        if (load_en)
          rd_q <= lane_mem[word_idx];
        if (store_en && lane_en[gi])
          lane_mem[word_idx] <= wr_data[8*gi +: 8];
      end
      assign raw_word[8*gi +: 8] = rd_q;
    end
  endgenerate

  logic        valid_out_reg, mem_to_reg_reg, reg_write_reg, misalign_reg;
  logic [31:0] dir_reg;
  logic [4:0]  rd_out_reg;
  logic        ld_sel_reg, uns_reg;
  logic [1:0]  size_reg, off_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      reg_write_reg  <= 1'b0;
      misalign_reg   <= 1'b0;
      dir_reg        <= '0;
      rd_out_reg     <= '0;
      ld_sel_reg     <= 1'b0;
      uns_reg        <= 1'b0;
      size_reg       <= '0;
      off_reg        <= '0;
    end else if (!bus.hold) begin
      if (bus.valid_in) begin
        valid_out_reg  <= 1'b1;
        mem_to_reg_reg <= bus.mem_to_reg_in;
        reg_write_reg  <= bus.reg_write_in & ~misalign_now;
        misalign_reg   <= misalign_now & (bus.mem_read | bus.mem_write);
        dir_reg        <= bus.alu_result;
        rd_out_reg     <= bus.rd_in;
        ld_sel_reg     <= bus.mem_read;
        uns_reg        <= bus.unsigned_ld;
        size_reg       <= bus.size;
        off_reg        <= byte_off;
      end else begin
        // Bubble: data_in/dir/rd_out keep their last values.
        valid_out_reg  <= 1'b0;
        mem_to_reg_reg <= 1'b0;
        reg_write_reg  <= 1'b0;
        misalign_reg   <= 1'b0;
      end
    end
  end

  // Lane extraction happens after the RAM read register, from captured size/offset.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    ld_byte = raw_word[7:0];
    case (off_reg)
      2'd1:    ld_byte = raw_word[15:8];
      2'd2:    ld_byte = raw_word[23:16];
      2'd3:    ld_byte = raw_word[31:24];
      default: ld_byte = raw_word[7:0];
    endcase
    ld_half = off_reg[1] ? raw_word[31:16] : raw_word[15:0];
    case (size_reg)
      2'b00:   ld_ext = uns_reg ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = uns_reg ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = raw_word;
    endcase
  end

  assign bus.valid_out  = valid_out_reg;
  assign bus.mem_to_reg = mem_to_reg_reg;
  assign bus.reg_write  = reg_write_reg;
  assign bus.misalign   = misalign_reg;
  assign bus.dir        = dir_reg;
  assign bus.rd_out     = rd_out_reg;
  assign bus.data_in    = ld_sel_reg ? ld_ext : 32'd0;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: word/byte/half accesses, misalignment, hold,
// bubbles, address wrap and asynchronous reset, against hand-computed values.
module tb_mem_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  mem_stage_if bus ();

  mem_stage #(.ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic m2r, input logic rw,
                         input logic mis, input logic [31:0] din, input logic [31:0] dr,
                         input logic [4:0] rd);
    chk({tag, ".valid_out"},  {31'd0, bus.valid_out},  {31'd0, v});
    chk({tag, ".mem_to_reg"}, {31'd0, bus.mem_to_reg}, {31'd0, m2r});
    chk({tag, ".reg_write"},  {31'd0, bus.reg_write},  {31'd0, rw});
    chk({tag, ".misalign"},   {31'd0, bus.misalign},   {31'd0, mis});
    chk({tag, ".data_in"},    bus.data_in,             din);
    chk({tag, ".dir"},        bus.dir,                 dr);
    chk({tag, ".rd_out"},     {27'd0, bus.rd_out},     {27'd0, rd});
  endtask

  task automatic drive(input logic v, input logic rd_op, input logic wr_op, input logic m2r,
                       input logic rw, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rdi);
    bus.valid_in      = v;
    bus.mem_read      = rd_op;
    bus.mem_write     = wr_op;
    bus.mem_to_reg_in = m2r;
    bus.reg_write_in  = rw;
    bus.size          = sz;
    bus.unsigned_ld   = uns;
    bus.alu_result    = addr;
    bus.store_data    = sd;
    bus.rd_in         = rdi;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.hold = 1'b0;
    drive(0, 0, 0, 0, 0, 2'd2, 0, 32'h0, 32'h0, 5'd0);
    #1 reset = 1'b1;
    #1 chk_out("reset", 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    tick();
    tick();
    #2 reset = 1'b0;
    tick();
    chk_out("post_reset_idle", 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);

    // Word store/load
    drive(1, 0, 1, 0, 0, 2'd2, 0, 32'h00, 32'h11111111, 5'd1); tick();
    chk_out("sw_0", 1, 0, 0, 0, 32'h0, 32'h00, 5'd1);
    drive(1, 0, 1, 0, 0, 2'd2, 0, 32'h04, 32'hAAAAAAAA, 5'd2); tick();
    chk_out("sw_4", 1, 0, 0, 0, 32'h0, 32'h04, 5'd2);
    drive(1, 1, 0, 1, 1, 2'd2, 0, 32'h04, 32'h0, 5'd5); tick();
    chk_out("lw_4", 1, 1, 1, 0, 32'hAAAAAAAA, 32'h04, 5'd5);

    // Byte/half extension
    drive(1, 0, 1, 0, 0, 2'd2, 0, 32'h08, 32'h0000FF80, 5'd0); tick();
    chk_out("sw_8", 1, 0, 0, 0, 32'h0, 32'h08, 5'd0);
    drive(1, 1, 0, 1, 1, 2'd0, 0, 32'h08, 32'h0, 5'd6); tick();
    chk_out("lb_8", 1, 1, 1, 0, 32'hFFFFFF80, 32'h08, 5'd6);
    drive(1, 1, 0, 1, 1, 2'd0, 1, 32'h08, 32'h0, 5'd6); tick();
    chk("lbu_8", bus.data_in, 32'h00000080);
    drive(1, 1, 0, 1, 1, 2'd1, 0, 32'h08, 32'h0, 5'd6); tick();
    chk("lh_8", bus.data_in, 32'hFFFFFF80);
    drive(1, 1, 0, 1, 1, 2'd0, 0, 32'h09, 32'h0, 5'd6); tick();
    chk("lb_9", bus.data_in, 32'hFFFFFFFF);
    chk("lb_9.dir", bus.dir, 32'h09);
    drive(1, 1, 0, 1, 1, 2'd1, 1, 32'h08, 32'h0, 5'd6); tick();
    chk("lhu_8", bus.data_in, 32'h0000FF80);
    drive(1, 1, 0, 1, 1, 2'd3, 1, 32'h08, 32'h0, 5'd6); tick();
    chk("lw_sz3_8", bus.data_in, 32'h0000FF80);

    // Misaligned accesses
    drive(1, 0, 1, 0, 0, 2'd2, 0, 32'h0C, 32'hCAFEF00D, 5'd0); tick();
    drive(1, 0, 1, 0, 1, 2'd2, 0, 32'h0D, 32'hDEADBEEF, 5'd4); tick();
    chk_out("sw_mis_D", 1, 0, 0, 1, 32'h0, 32'h0D, 5'd4);
    drive(1, 1, 0, 1, 1, 2'd2, 0, 32'h0C, 32'h0, 5'd6); tick();
    chk_out("lw_C_unchanged", 1, 1, 1, 0, 32'hCAFEF00D, 32'h0C, 5'd6);
    drive(1, 1, 0, 1, 1, 2'd1, 0, 32'h03, 32'h0, 5'd8); tick();
    chk_out("lh_mis_3", 1, 1, 0, 1, 32'h00001111, 32'h03, 5'd8);

    // Sub-word stores land in the selected lanes only
    drive(1, 0, 1, 0, 0, 2'd0, 0, 32'h0E, 32'hFFFFFF77, 5'd0); tick();
    chk("sb_E.misalign", {31'd0, bus.misalign}, 32'h0);
    drive(1, 1, 0, 1, 1, 2'd2, 0, 32'h0C, 32'h0, 5'd6); tick();
    chk("lw_C_after_sb", bus.data_in, 32'hCA77F00D);
    drive(1, 0, 1, 0, 0, 2'd1, 0, 32'h0E, 32'hABCD1234, 5'd0); tick();
    drive(1, 1, 0, 1, 1, 2'd2, 0, 32'h0C, 32'h0, 5'd6); tick();
    chk("lw_C_after_sh", bus.data_in, 32'h1234F00D);

    // Load and store together: pre-store word is returned
    drive(1, 1, 1, 1, 1, 2'd2, 0, 32'h0C, 32'h0BADCAFE, 5'd6); tick();
    chk("lsw_C_old", bus.data_in, 32'h1234F00D);
    drive(1, 1, 0, 1, 1, 2'd2, 0, 32'h0C, 32'h0, 5'd6); tick();
    chk("lw_C_new", bus.data_in, 32'h0BADCAFE);

    // Hold
    drive(1, 0, 1, 0, 0, 2'd2, 0, 32'h10, 32'h00000000, 5'd0); tick();
    drive(1, 1, 0, 1, 1, 2'd2, 0, 32'h04, 32'h0, 5'd7); tick();
    bus.hold = 1'b1;
    drive(1, 0, 1, 0, 0, 2'd2, 0, 32'h10, 32'h12345678, 5'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("hold_frozen", 1, 1, 1, 0, 32'hAAAAAAAA, 32'h04, 5'd7);
    end
    bus.hold = 1'b0;
    drive(1, 1, 0, 1, 1, 2'd2, 0, 32'h10, 32'h0, 5'd9); tick();
    chk_out("hold_no_store", 1, 1, 1, 0, 32'h0, 32'h10, 5'd9);
    bus.hold = 1'b1;
    drive(1, 0, 1, 0, 0, 2'd2, 0, 32'h10, 32'h12345678, 5'd3); tick();
    chk_out("hold_frozen2", 1, 1, 1, 0, 32'h0, 32'h10, 5'd9);
    bus.hold = 1'b0; tick();
    chk_out("hold_release", 1, 0, 0, 0, 32'h0, 32'h10, 5'd3);
    drive(1, 1, 0, 1, 1, 2'd2, 0, 32'h10, 32'h0, 5'd9); tick();
    chk("lw_10", bus.data_in, 32'h12345678);

    // Bubble with a stray store request must neither store nor clear data
    drive(0, 0, 1, 1, 1, 2'd2, 0, 32'h10, 32'hFFFFFFFF, 5'd2); tick();
    chk_out("bubble", 0, 0, 0, 0, 32'h12345678, 32'h10, 5'd9);
    drive(1, 1, 0, 1, 1, 2'd2, 0, 32'h10, 32'h0, 5'd9); tick();
    chk("lw_10_after_bubble", bus.data_in, 32'h12345678);

    // Address wrap
    drive(1, 0, 1, 0, 0, 2'd0, 0, 32'h400, 32'h0000005A, 5'd0); tick();
    chk_out("sb_wrap", 1, 0, 0, 0, 32'h0, 32'h400, 5'd0);
    drive(1, 1, 0, 1, 1, 2'd0, 1, 32'h000, 32'h0, 5'd10); tick();
    chk_out("lbu_0", 1, 1, 1, 0, 32'h0000005A, 32'h0, 5'd10);
    drive(1, 1, 0, 1, 1, 2'd2, 0, 32'h000, 32'h0, 5'd10); tick();
    chk("lw_0", bus.data_in, 32'h1111115A);

    // Asynchronous reset with a store in flight
    drive(1, 0, 1, 1, 1, 2'd2, 0, 32'h000, 32'hBBBBBBBB, 5'd11);
    #2 reset = 1'b1;
    #1 chk_out("reset_async", 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    tick();
    chk_out("reset_held", 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    #2 reset = 1'b0;
    #1 chk_out("reset_released", 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    drive(1, 1, 0, 1, 1, 2'd2, 0, 32'h000, 32'h0, 5'd12); tick();
    chk_out("first_after_reset", 1, 1, 1, 0, 32'h1111115A, 32'h0, 5'd12);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipeline: performs data-memory loads and stores for the instruction leaving EX and holds the MEM/WB pipeline register that feeds `wb_stage`. It produces exactly the signals `wb_stage` consumes (`mem_to_reg`, `data_in`, `dir`) plus the register-file write controls. Loads and stores support byte, half and word sizes, with sign/zero extension and misalignment detection.

## Interface
- `ADDR_W`, default 8: log2 of data-memory depth in 32-bit words (256 words).
- `clk  in  1`: stage clock; all state updates on its rising edge.
- `reset  in  1`: asynchronous, active-high; clears the MEM/WB register. Memory contents are not cleared.
- `hold  in  1`: pipeline stall; freezes the MEM/WB register and suppresses stores.
- `valid_in  in  1`: an instruction is present at the stage input.
- `mem_read  in  1`: instruction is a load.
- `mem_write  in  1`: instruction is a store.
- `mem_to_reg_in  in  1`: write-back selects memory data.
- `reg_write_in  in  1`: instruction writes the register file.
- `size  in  2`: access size. 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `unsigned_ld  in  1`: 1 = zero-extend, 0 = sign-extend byte/half loads.
- `alu_result  in  32`: effective address; also the ALU result forwarded to write-back.
- `store_data  in  32`: store source register value.
- `rd_in  in  5`: destination register.
- `valid_out  out  1`: MEM/WB holds a valid instruction.
- `mem_to_reg  out  1`: to `wb_stage.mem_to_reg`.
- `reg_write  out  1`: register-file write enable.
- `data_in  out  32`: extended load data, to `wb_stage.data_in`.
- `dir  out  32`: registered `alu_result`, to `wb_stage.dir`.
- `rd_out  out  5`: registered destination register.
- `misalign  out  1`: registered misaligned-access flag.

## Operation
- **Word index.** The word index is `alu_result[ADDR_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo 4·2^ADDR_W bytes.
- **Byte lanes.** Lanes are little-endian: byte offset k = `alu_result[1:0]` selects bits [8k+7:8k]. A half access at offset 0 uses bits [15:0]; at offset 2 it uses bits [31:16].
- **Misalignment.**
  - half: misaligned when `alu_result[0]`=1.
  - word: misaligned when `alu_result[1:0]`≠0.
  - byte: never misaligned.
- **Access qualifier.** An access is active when `valid_in & ~hold & (mem_read | mem_write)`.
- **Store.** An active, aligned store writes only the selected lanes at the clock edge. The source is `store_data[7:0]` for byte stores and `store_data[15:0]` for half stores, replicated across lanes. Misaligned stores write nothing.
- **Load.** The word at the index is read (pre-write contents). The selected lane is extracted and then sign-extended or zero-extended into `data_in`. A word load passes the word through unchanged.
- **Load and store together.** When `mem_read` and `mem_write` are both 1, the store is performed. `data_in` captures the pre-store word, extracted and extended as a load.
- **Update on valid_in=1.** When `~hold & valid_in`, the MEM/WB register loads:
  - `valid_out`=1
  - `mem_to_reg`=`mem_to_reg_in`
  - `reg_write`=`reg_write_in & ~misalign_now`
  - `dir`=`alu_result`
  - `rd_out`=`rd_in`
  - `misalign`=`misalign_now & (mem_read|mem_write)`
  - `data_in`=load result, or 0 if the instruction is not a load.
- **Update on valid_in=0 (bubble).** When `~hold & ~valid_in`, the register loads `valid_out`=0, `reg_write`=0, `mem_to_reg`=0 and `misalign`=0. `data_in`, `dir` and `rd_out` hold their previous values.
- **Hold.** While `hold`=1, every MEM/WB bit holds and no store occurs, regardless of `valid_in`.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N. Stores are visible to a load sampled at edge N+1.
- Back-to-back instructions are accepted every cycle. A store at edge N followed by a load of the same word at edge N+1 returns the new data.
- While `reset` is asserted, asynchronously: all outputs are 0 (`valid_out`, `mem_to_reg`, `reg_write`, `misalign`, `data_in`, `dir`, `rd_out`).
- No store occurs while `reset`=1. An instruction in flight when reset asserts is discarded.
- After reset deasserts, the first edge with `valid_in`=1 produces a valid output.
- The memory array is not reset. Reads of never-written words return undefined data, and benches must initialise every word they read.

## Test plan
- **Reset.** Assert reset mid-stream with `valid_in`=1 -> all outputs immediately 0. The first instruction after release appears one edge later.
- **Word store/load.** Store word 0xAAAAAAAA to address 0x04, then load a word from 0x04 with `mem_to_reg_in`=1 -> `data_in`=0xAAAAAAAA, `dir`=0x00000004, `mem_to_reg`=1 one cycle after the load.
- **Byte/half extension.** Store 0x0000FF80 to address 0x08. Then:
  - load byte at 0x08, signed -> `data_in`=0xFFFFFF80
  - same load, unsigned -> 0x00000080
  - load half at 0x08, signed -> 0xFFFFFF80
  - load byte at 0x09 -> 0xFFFFFFFF
- **Misaligned accesses.** Word store to 0x0D -> memory unchanged, `misalign`=1, `reg_write`=0. Half load from 0x03 -> `misalign`=1, `reg_write`=0.
- **Hold.** Assert `hold` with a store of 0x12345678 to 0x10 -> memory unchanged and outputs frozen for every held cycle. Release -> the store takes effect one edge later.
- **Address wrap.** Store 0x5A to byte address 0x400 (ADDR_W=8) -> a byte load at 0x000 returns 0x0000005A.
